// File: rtl/hop_scheduler.sv
// hop_scheduler: game-flow controller for the vertical scroll datapath.
//
// Conditions the raw hop/start buttons (2-flop sync + debounce + one-cycle
// press strobe), keeps a small queue of hop requests and holds scroll_en high
// for exactly HOP_FRAMES frame_tick pulses per queued hop. Also tracks the
// game state and a saturating score of completed hops.
//
// Ports:
//   clk        in   1   system clock (25 MHz pixel clock)
//   rst_n      in   1   asynchronous active-low reset
//   btn_hop    in   1   raw hop button, asynchronous to clk
//   btn_start  in   1   raw start button, asynchronous to clk
//   frame_tick in   1   one-cycle strobe per video frame
//   collision  in   1   collision level from the render logic
//   scroll_en  out  1   move enable to the scroll datapath (high in HOP)
//   game_state out  2   FSM state: 0=IDLE 1=RUN 2=HOP 3=DEAD
//   pending    out  2   number of queued hops
//   score      out  10  completed hops, saturating at SCORE_MAX
//
// Interface timing: frame_tick and the internal press strobes are single-cycle
// pulses with no back-pressure; an event is consumed on the clock edge where
// its strobe is high, and there is no way to stall or retry it.

module hop_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any agreement restarts the window, so bounces shorter than
      // DB_CYCLES never reach the stable value.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable_q <= stable;
      // Rising edge only: a release never produces a press.
      press    <= stable & ~stable_q;
    end
  end

endmodule

module hop_scheduler #(
  parameter int DB_CYCLES  = 250000,
  parameter int HOP_FRAMES = 8,
  parameter int MAX_PEND   = 3,
  parameter int SCORE_MAX  = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_hop,
  input  logic       btn_start,
  input  logic       frame_tick,
  input  logic       collision,
  output logic       scroll_en,
  output logic [1:0] game_state,
  output logic [1:0] pending,
  output logic [9:0] score
);

  localparam int FCW = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST   = FCW'(HOP_FRAMES - 1);
  localparam logic [9:0]     SCORE_LIM = 10'(SCORE_MAX);
  localparam logic [2:0]     PEND_LIM  = 3'(MAX_PEND);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOP  = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [1:0]     pend_n;
  logic [FCW-1:0] frame_cnt;
  logic [FCW-1:0] frame_cnt_n;
  logic [9:0]     score_n;
  logic           hop_press;
  logic           start_press;
  logic           enq;
  logic           deq;

  hop_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_hop (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_hop),
    .press (hop_press)
  );

  hop_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_start),
    .press (start_press)
  );

  // Queue update: an enqueue and a dequeue in the same cycle cancel out,
  // then the result is clamped so extra presses are dropped. deq is only
  // raised while the queue is non-empty, so the sum never underflows.
  function automatic logic [1:0] next_pend(input logic [1:0] p,
                                           input logic       e,
                                           input logic       d);
    logic [2:0] s;
    s = {1'b0, p} + {2'b00, e} - {2'b00, d};
    if (s > PEND_LIM) s = PEND_LIM;
    return s[1:0];
  endfunction

  always_comb begin
    state_n     = state;
    pend_n      = pending;
    frame_cnt_n = frame_cnt;
    score_n     = score;
    enq         = 1'b0;
    deq         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          state_n = S_RUN;
          score_n = '0;
          pend_n  = '0;
        end
      end
      S_RUN: begin
        // Collision wins over everything, including a press this cycle.
        if (collision) begin
          state_n = S_DEAD;
          pend_n  = '0;
        end else begin
          enq = hop_press;
          if (pending != 2'd0) begin
            deq         = 1'b1;
            state_n     = S_HOP;
            frame_cnt_n = '0;
          end
          pend_n = next_pend(pending, enq, deq);
        end
      end
      S_HOP: begin
        if (collision) begin
          state_n = S_DEAD;
          pend_n  = '0;
        end else begin
          enq = hop_press;
          if (frame_tick) begin
            if (frame_cnt == FC_LAST) begin
              score_n     = (score >= SCORE_LIM) ? SCORE_LIM : score + 10'd1;
              frame_cnt_n = '0;
              // Chain straight into the next queued hop without leaving HOP,
              // so scroll_en has no gap cycle.
              if (pending != 2'd0) begin
                deq = 1'b1;
              end else begin
                state_n = S_RUN;
              end
            end else begin
              frame_cnt_n = frame_cnt + 1'b1;
            end
          end
          pend_n = next_pend(pending, enq, deq);
        end
      end
      S_DEAD: begin
        if (start_press) begin
          state_n = S_RUN;
          score_n = '0;
          pend_n  = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      frame_cnt <= '0;
      score     <= '0;
      scroll_en <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pend_n;
      frame_cnt <= frame_cnt_n;
      score     <= score_n;
      // Registered from the next state so it tracks (state == HOP) exactly.
      scroll_en <= (state_n == S_HOP);
    end
  end

  assign game_state = state;

endmodule

// File: doc/hop_scheduler.md
Name: hop_scheduler

Overview:
- Game-flow controller that sequences the vertical scroll datapath for the Crossy Road VGA game.
- Debounces the hop and start buttons and queues hop requests.
- Drives the scroll datapath's move enable for exactly one hop's worth of frames per request.
- Tracks game state (idle / run / hop / dead) and score; sits between the input pins and the scroll and render logic.

Parameters:
- DB_CYCLES, 250000, debounce stability window in clk cycles (10 ms at 25 MHz).
- HOP_FRAMES, 8, frame_tick pulses per hop (scroll_en high duration).
- MAX_PEND, 3, maximum queued hops; range 1..3.
- SCORE_MAX, 999, score saturation value.

Ports:
- clk  input  1  system clock (25 MHz pixel clock). Single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- btn_hop  input  1  raw hop button, asynchronous to clk.
- btn_start  input  1  raw start button, asynchronous to clk.
- frame_tick  input  1  one-cycle pulse per video frame, synchronous to clk.
- collision  input  1  level from the render/collision logic, synchronous to clk.
- scroll_en  output  1  move enable to the scroll datapath.
- game_state  output  2  0=IDLE, 1=RUN, 2=HOP, 3=DEAD.
- pending  output  2  number of queued hops.
- score  output  10  completed hops, saturating.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, scroll_en=0, pending=0, score=0.
  - Frame counter, debounce counters, sync flops and stable values all cleared to 0.
  - Reset taking effect mid-hop aborts the hop immediately.
- Input conditioning (per button):
  - 2-flop synchronizer, then debounce counter.
  - If synced==stable: counter=0.
  - Else: counter increments. When counter==DB_CYCLES-1 and still mismatched, stable<=synced and counter=0.
  - Press pulse = registered rising edge of stable, high exactly 1 cycle.
  - Latency: raw high sampled at edge k gives press high during cycle k+DB_CYCLES+3.
  - Bounces shorter than DB_CYCLES produce no press. Release generates no pulse.
- IDLE:
  - start_press -> RUN; score=0, pending=0.
  - hop_press is ignored.
- RUN:
  - hop_press: pending=min(pending+1, MAX_PEND). Presses beyond MAX_PEND are dropped silently.
  - If pending!=0: next cycle -> HOP, pending decremented, frame_cnt=0.
  - Press in the same cycle as a dequeue: pending net unchanged.
- HOP:
  - scroll_en=1, registered; scroll_en equals (state==HOP) with no extra latency.
  - hop_press still enqueues, with the same saturation rule.
  - Each frame_tick increments frame_cnt.
  - On the frame_tick where frame_cnt==HOP_FRAMES-1: score=min(score+1, SCORE_MAX).
    - If pending!=0: stay in HOP, frame_cnt=0, pending decremented. scroll_en stays high with no gap cycle.
    - Else: -> RUN, scroll_en=0.
  - A hop started mid-frame counts its first frame_tick as frame 1. Partial frames are not compensated.
- Collision (RUN or HOP, collision==1):
  - Next state is DEAD, scroll_en=0, pending=0.
  - Collision beats hop completion in the same cycle: no score increment.
  - Collision beats hop_press: the press is discarded.
- DEAD:
  - score is frozen; hop_press and collision are ignored.
  - start_press -> RUN; score=0, pending=0.
- start_press in RUN or HOP is ignored.
- Width rules:
  - frame_cnt sized for HOP_FRAMES-1.
  - score never wraps: it holds at SCORE_MAX.
  - pending never exceeds MAX_PEND and never underflows.

Test Plan:
(Bench parameters: DB_CYCLES=4, HOP_FRAMES=2, MAX_PEND=3, SCORE_MAX=999.)
- Reset mid-hop: assert rst_n=0 while state=HOP with pending=2 -> scroll_en=0, state=0, pending=0, score=0 immediately (async). No change after release until start_press.
- Debounce: btn_hop toggles 1,0,1 each for 2 cycles, then high for 10 cycles, state=RUN -> no press from the glitches. Exactly one press: pending goes 0->1, then HOP begins the next cycle.
- Single hop: from RUN, one press, then 3 frame_ticks -> scroll_en high from the cycle after dequeue until the cycle after the 2nd frame_tick. score=1, state back to 1.
- Queue saturation: 5 presses during one hop -> pending caps at 3. score reaches 4 after 4 back-to-back hops, scroll_en continuously high across all of them. Then state=RUN, pending=0.
- Collision priority: collision asserted in the same cycle as the completing frame_tick -> state=3, score unchanged, scroll_en=0, pending=0. Later hop presses are ignored.
- Restart and saturation: in DEAD with score=7, start_press -> RUN, score=0. Force score=999 and complete a hop -> score stays 999.
